imem_load_ctrl: RTL

- Controls the instruction RAM's single port and shares it between two users: CPU instruction fetch in normal run, and a UART boot loader while load_imem is high.
- In load mode it receives a byte stream on uart0_rxd and packs the bytes little-endian into 32-bit words. It writes the words to sequential imem word addresses from 0 and holds the CPU in reset.
- Sits in AppleSoC_arty between cpu_core, soc_imem_inst and the uart0_rxd pad. It replaces backdoor imem preloading on hardware.

---
 rtl/apple_soc_pkg.sv | 14 +
 rtl/imem_load_ctrl_if.sv | 12 +
 rtl/imem_uart_rx.sv | 75 +++++++
 rtl/imem_load_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/apple_soc_pkg.sv
// apple_soc_pkg: shared loader/UART types, frame constants and baud helper
package apple_soc_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RELEASE} load_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
  // Byte enables for the lanes already filled when a load ends mid-word
  function automatic logic [3:0] partial_mask(input logic [1:0] idx);
    return 4'((5'd1 << idx) - 5'd1);
  endfunction
endpackage

// File: rtl/imem_load_ctrl_if.sv
// imem_load_ctrl_if: CPU fetch request in, shared imem port out
interface imem_load_ctrl_if #(parameter int AW = 14);
  logic [AW-1:0] cpu_imem_addr;
  logic cpu_imem_rd;
  logic [AW-1:0] imem_addr;
  logic imem_rd;
  logic imem_wr;
  logic [31:0] imem_wdata;
  logic [3:0] imem_byte_en;
  modport master(input cpu_imem_addr, cpu_imem_rd, output imem_addr, imem_rd, imem_wr, imem_wdata, imem_byte_en);
  modport slave(output cpu_imem_addr, cpu_imem_rd, input imem_addr, imem_rd, imem_wr, imem_wdata, imem_byte_en);
endinterface

// File: rtl/imem_uart_rx.sv
// imem_uart_rx: 8N1 UART receiver with input synchroniser and mid-bit sampling
module imem_uart_rx
  import apple_soc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_e st;
  logic [1:0] sync;
  logic rxd_s;
  logic [CW-1:0] cnt;
  logic [2:0] bits;
  logic [7:0] shift;
  assign rxd_s = sync[1];
  // A bad stop bit parks in RX_WAIT until the line idles, so a held-low line is not read as a new start
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= RX_IDLE;
      sync <= 2'b11;
      cnt <= '0;
      bits <= '0;
      shift <= '0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      sync <= {sync[0], rxd};
      rx_valid <= 1'b0;
      rx_frame_err <= 1'b0;
      cnt <= cnt + 1'b1;
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (!rxd_s) st <= RX_START;
        end
        RX_START: if (cnt == HALF) begin
          cnt <= '0;
          bits <= '0;
          st <= rxd_s ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (cnt == FULL) begin
          cnt <= '0;
          shift <= {rxd_s, shift[7:1]};
          bits <= bits + 1'b1;
          if (bits == 3'(UART_DATA_BITS - 1)) begin
            bits <= '0;
            st <= RX_STOP;
          end
        end
        RX_STOP: if (cnt == FULL) begin
          cnt <= '0;
          if (!rxd_s) begin
            rx_frame_err <= 1'b1;
            st <= RX_WAIT;
          end else if (bits == 3'(UART_STOP_BITS - 1)) begin
            rx_valid <= 1'b1;
            rx_data <= shift;
            st <= RX_IDLE;
          end else bits <= bits + 1'b1;
        end
        RX_WAIT: if (rxd_s) st <= RX_IDLE;
        default: st <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: shares the imem port between CPU fetch and a UART boot loader
module imem_load_ctrl
  import apple_soc_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH = 14,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD = 115200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_imem,
  input  logic                     uart0_rxd,
  imem_load_ctrl_if.master         bus,
  output logic                     cpu_hold,
  output logic                     load_busy,
  output logic [IMEM_ADDR_WIDTH:0] load_words,
  output logic                     load_err
);
  load_state_e state;
  logic [IMEM_ADDR_WIDTH-1:0] ptr;
  logic [1:0] idx, idx_next;
  logic [2:0] ld_sync;
  logic rise, fall;
  logic rx_valid, rx_frame_err;
  logic [7:0] rx_data;
  logic wr;
  logic [31:0] wdata;
  logic [3:0] be;
  imem_uart_rx #(.CLKS_PER_BIT(clks_per_bit(CLK_FREQ_HZ, BAUD))) u_rx (
    .clk(clk),
    .reset(reset),
    .rxd(uart0_rxd),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_frame_err(rx_frame_err)
  );
  assign rise = ld_sync[1] & ~ld_sync[2];
  assign fall = ~ld_sync[1] & ld_sync[2];
  assign idx_next = rx_valid ? idx + 2'd1 : idx;
  assign bus.imem_addr = state == IDLE ? bus.cpu_imem_addr : ptr;
  assign bus.imem_rd = state == IDLE & bus.cpu_imem_rd;
  assign bus.imem_wr = wr;
  assign bus.imem_wdata = wdata;
  assign bus.imem_byte_en = be;
  // Pointer and word count advance in the cycle after each write pulse, whatever the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      idx <= '0;
      ld_sync <= '0;
      wr <= 1'b0;
      wdata <= '0;
      be <= '0;
      cpu_hold <= 1'b0;
      load_busy <= 1'b0;
      load_words <= '0;
      load_err <= 1'b0;
    end else begin
      ld_sync <= {ld_sync[1:0], load_imem};
      wr <= 1'b0;
      if (wr) begin
        ptr <= ptr + 1'b1;
        load_words <= load_words + 1'b1;
        if (&ptr) load_err <= 1'b1;
      end
      case (state)
        IDLE: if (rise) begin
          state <= LOAD;
          cpu_hold <= 1'b1;
          load_busy <= 1'b1;
          ptr <= '0;
          idx <= '0;
          load_words <= '0;
          load_err <= 1'b0;
        end
        LOAD: begin
          if (rx_frame_err) load_err <= 1'b1;
          if (rx_valid) begin
            wdata[8*idx +: 8] <= rx_data;
            idx <= idx_next;
          end
          if (rx_valid && idx == 2'd3) begin
            wr <= 1'b1;
            be <= 4'hF;
          end
          if (fall) state <= idx_next == 2'd0 ? RELEASE : FLUSH;
        end
        FLUSH: begin
          wr <= 1'b1;
          be <= partial_mask(idx);
          idx <= '0;
          state <= RELEASE;
        end
        RELEASE: begin
          cpu_hold <= 1'b0;
          load_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
